bit_packer: RTL and testbench

Serial-to-symbol packer feeding the universal modulator. Accepts one data bit per valid/ready handshake, optionally whitens it with an additive PN7 scrambler, and groups bits MSB-first into symbols whose width equals the bits-per-symbol of the selected modulation. Output is a registered valid/ready stream that drives the modulator's `dIn`/`valIn`/`rdyIn`.

---
 rtl/mod_pkg.sv | 21 ++
 rtl/pn7_scrambler.sv | 31 +++
 rtl/bit_packer.sv | 109 ++++++++++
 tb/tb_bit_packer.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mod_pkg.sv
// Shared modulation definitions: bits-per-symbol lookup and PN7 scrambler constants.
// Imported by the serial-to-symbol packer and its scrambler.
package mod_pkg;

    localparam int LFSR_W = 7;
    localparam logic [LFSR_W-1:0] DEFAULT_SEED = 7'h7F;

    // Feedback taps of x^7 + x^6 + 1
    localparam int TAP_A = 6;
    localparam int TAP_B = 5;

    function automatic int bps(input string modType);
        if (modType == "BPSK")  return 1;
        if (modType == "QPSK")  return 2;
        if (modType == "8PSK")  return 3;
        if (modType == "QAM16") return 4;
        if (modType == "QAM64") return 6;
        return 2;
    endfunction

endpackage

// File: rtl/pn7_scrambler.sv
// Additive PN7 whitener: bitOut = bitIn ^ keystream; the LFSR steps only when adv is high.
// A reseed takes priority over an advance.
module pn7_scrambler
    import mod_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = DEFAULT_SEED
) (
    input  logic clk,
    input  logic rst,
    input  logic adv,
    input  logic reseed,
    input  logic bitIn,
    output logic bitOut
);

    logic [LFSR_W-1:0] lfsr;
    logic              fb;

    assign fb     = lfsr[TAP_A] ^ lfsr[TAP_B];
    assign bitOut = bitIn ^ fb;

    // The same-cycle bit is scrambled combinationally before a reseed lands.
    always_ff @(posedge clk) begin
        if (rst || reseed) begin
            lfsr <= SEED;
        end else if (adv) begin
            lfsr <= {lfsr[LFSR_W-2:0], fb};
        end
    end

endmodule

// File: rtl/bit_packer.sv
// Serial-to-symbol packer: accepts one bit per handshake, optionally whitens it, and groups
// bits MSB-first into OWIDTH-bit symbols on a registered valid/ready output.
module bit_packer
    import mod_pkg::*;
#(
    parameter string             MODTYPE  = "QPSK",
    parameter bit                SCRAMBLE = 1'b1,
    parameter logic [LFSR_W-1:0] SEED     = DEFAULT_SEED,
    localparam int               OWIDTH   = bps(MODTYPE)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              dIn,
    input  logic              valIn,
    output logic              rdyIn,
    input  logic              flush,
    output logic [OWIDTH-1:0] dOut,
    output logic              valOut,
    input  logic              rdyOut
);

    localparam int CNT_W = 3;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(OWIDTH - 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(OWIDTH);

    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cntAfter;
    logic [OWIDTH-1:0] sh;
    logic [OWIDTH-1:0] shAfter;
    logic              flushPend;
    logic              acc;
    logic              bitS;
    logic              outFree;
    logic              symFull;
    logic              partial;
    logic              partEmit;
    logic              partWait;

    // Move the n collected bits (held in the LSBs) to the top, zero-filling the rest.
    function automatic logic [OWIDTH-1:0] leftAlign(input logic [OWIDTH-1:0] s,
                                                     input logic [CNT_W-1:0]  n);
        return s << (FULL - n);
    endfunction

    assign outFree = !valOut || rdyOut;
    assign rdyIn   = !rst && outFree && !flushPend;
    assign acc     = valIn && rdyIn;

    if (SCRAMBLE) begin : gScr
        pn7_scrambler #(
            .SEED(SEED)
        ) uScr (
            .clk   (clk),
            .rst   (rst),
            .adv   (acc),
            .reseed(flush),
            .bitIn (dIn),
            .bitOut(bitS)
        );
    end else begin : gBypass
        assign bitS = dIn;
    end

    // Shift/count state as it stands once this cycle's bit is included.
    always_comb begin
        shAfter  = sh;
        cntAfter = cnt;
        if (acc) begin
            shAfter  = OWIDTH'({sh, bitS});
            cntAfter = cnt + 1'b1;
        end
    end

    assign symFull  = acc && (cnt == LAST);
    assign partial  = (flush || flushPend) && !symFull && (cntAfter != '0);
    assign partEmit = partial && outFree;
    assign partWait = partial && !outFree;

    // Stale bits above the fill level are shifted out, so the data shift register needs no reset.
    always_ff @(posedge clk) begin
        sh <= shAfter;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            valOut    <= 1'b0;
            dOut      <= '0;
            flushPend <= 1'b0;
        end else begin
            if (symFull) begin
                dOut   <= shAfter;
                valOut <= 1'b1;
                cnt    <= '0;
            end else if (partEmit) begin
                dOut   <= leftAlign(shAfter, cntAfter);
                valOut <= 1'b1;
                cnt    <= '0;
            end else begin
                if (rdyOut) begin
                    valOut <= 1'b0;
                end
                cnt <= cntAfter;
            end
            flushPend <= partWait;
        end
    end

endmodule

// File: tb/tb_bit_packer.sv
// Bench for bit_packer: four configurations side by side, table vectors, hand-written
// corner sequences and random handshakes checked against a PN-sequence reference.
module tb_bit_packer;

    logic       clk = 1'b0;
    logic [3:0] rst;
    logic [3:0] valIn;
    logic [3:0] flush;
    logic [3:0] rdyOut;
    logic [3:0] rdyIn;
    logic [3:0] valOut;
    logic       dIn;
    logic [1:0] d0;
    logic [1:0] d1;
    logic [3:0] d2;
    logic       d3;
    logic [5:0] dOutA [4];

    int total = 0;
    int bad   = 0;

    bit pnSeq [0:299];

    typedef struct {
        int         inst;
        bit         v;
        bit         d;
        bit         f;
        bit         expV;
        logic [5:0] expD;
    } vec_t;

    vec_t tbl[$];

    always #5 clk = ~clk;

    assign dOutA[0] = {4'b0, d0};
    assign dOutA[1] = {4'b0, d1};
    assign dOutA[2] = {2'b0, d2};
    assign dOutA[3] = {5'b0, d3};

    bit_packer #(.MODTYPE("QPSK"), .SCRAMBLE(1'b0)) u0 (
        .clk(clk), .rst(rst[0]), .dIn(dIn), .valIn(valIn[0]), .rdyIn(rdyIn[0]),
        .flush(flush[0]), .dOut(d0), .valOut(valOut[0]), .rdyOut(rdyOut[0]));
    bit_packer #(.MODTYPE("QPSK"), .SCRAMBLE(1'b1), .SEED(7'h7F)) u1 (
        .clk(clk), .rst(rst[1]), .dIn(dIn), .valIn(valIn[1]), .rdyIn(rdyIn[1]),
        .flush(flush[1]), .dOut(d1), .valOut(valOut[1]), .rdyOut(rdyOut[1]));
    bit_packer #(.MODTYPE("QAM16"), .SCRAMBLE(1'b0)) u2 (
        .clk(clk), .rst(rst[2]), .dIn(dIn), .valIn(valIn[2]), .rdyIn(rdyIn[2]),
        .flush(flush[2]), .dOut(d2), .valOut(valOut[2]), .rdyOut(rdyOut[2]));
    bit_packer #(.MODTYPE("BPSK"), .SCRAMBLE(1'b1), .SEED(7'h7F)) u3 (
        .clk(clk), .rst(rst[3]), .dIn(dIn), .valIn(valIn[3]), .rdyIn(rdyIn[3]),
        .flush(flush[3]), .dOut(d3), .valOut(valOut[3]), .rdyOut(rdyOut[3]));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset(input int k);
        rst[k] = 1'b1;
        cyc();
        cyc();
        rst[k] = 1'b0;
    endtask

    // Keystream bit n: the PN7 sequence a[] obeys a[n+7] = a[n] ^ a[n+1], seeded MSB-first.
    function automatic bit ks(input int n);
        return pnSeq[n + 7];
    endfunction

    function automatic vec_t mk(input int inst, input bit v, input bit d, input bit f,
                                input bit expV, input logic [5:0] expD);
        vec_t r;
        r.inst = inst; r.v = v; r.d = d; r.f = f; r.expV = expV; r.expD = expD;
        return r;
    endfunction

    task automatic runRandom(input int k, input int w, input bit scr);
        bit         src [100];
        int         sent   = 0;
        int         got    = 0;
        int         cycles = 0;
        int         nSym   = 100 / w;
        bit         accNow;
        bit         xfer;
        logic [5:0] exp;
        doReset(k);
        for (int i = 0; i < 100; i++) src[i] = 1'($urandom_range(0, 1));
        while (got < nSym && cycles < 3000) begin
            valIn[k]  = (sent < 100) && ($urandom_range(0, 3) != 0);
            dIn       = (sent < 100) ? src[sent] : 1'b0;
            rdyOut[k] = ($urandom_range(0, 3) != 0);
            #1;
            if (valOut[k] && !rdyOut[k]) check($sformatf("rnd%0d_bp_rdyIn", k), rdyIn[k], 0);
            accNow = valIn[k] && rdyIn[k];
            xfer   = valOut[k] && rdyOut[k];
            if (xfer) begin
                exp = '0;
                for (int j = 0; j < w; j++)
                    exp = {exp[4:0], src[got*w + j] ^ (scr & ks(got*w + j))};
                check($sformatf("rnd%0d_sym%0d", k, got), dOutA[k], exp);
                got++;
            end
            if (accNow) sent++;
            cyc();
            cycles++;
        end
        check($sformatf("rnd%0d_symcount", k), got, nSym);
        valIn[k]  = 1'b0;
        rdyOut[k] = 1'b1;
    endtask

    initial begin
        logic [6:0] seedV;
        bit         b3 [8];
        int         n;

        seedV = 7'h7F;
        for (int i = 0; i < 7; i++) pnSeq[i] = seedV[6-i];
        for (int i = 0; i < 293; i++) pnSeq[i+7] = pnSeq[i] ^ pnSeq[i+1];

        rst = '1; valIn = '0; flush = '0; rdyOut = '1; dIn = 1'b0;
        repeat (3) cyc();
        for (int k = 0; k < 4; k++) begin
            check($sformatf("reset_val%0d", k), valOut[k], 0);
            check($sformatf("reset_dout%0d", k), dOutA[k], 0);
            check($sformatf("reset_rdy%0d", k), rdyIn[k], 0);
        end
        rst = '0;
        cyc();

        // QPSK plain: 1,0,1,1 back-to-back
        tbl.push_back(mk(0, 1, 1, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 1, 6'b10));
        tbl.push_back(mk(0, 1, 1, 0, 0, 0));
        tbl.push_back(mk(0, 1, 1, 0, 1, 6'b11));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0));
        // QPSK scrambled: eight zeros give keystream 0000_0010
        for (int i = 0; i < 8; i++)
            tbl.push_back(mk(1, 1, 0, 0, i[0], (i == 7) ? 6'b10 : 6'b00));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0));
        // QAM16 plain: partial flush, empty flush, full symbol, flush with bit, flush on last bit
        tbl.push_back(mk(2, 1, 1, 0, 0, 0));
        tbl.push_back(mk(2, 1, 1, 0, 0, 0));
        tbl.push_back(mk(2, 1, 0, 0, 0, 0));
        tbl.push_back(mk(2, 0, 0, 1, 1, 6'b1100));
        tbl.push_back(mk(2, 0, 0, 0, 0, 0));
        tbl.push_back(mk(2, 0, 0, 1, 0, 0));
        tbl.push_back(mk(2, 0, 0, 0, 0, 0));
        tbl.push_back(mk(2, 1, 1, 0, 0, 0));
        tbl.push_back(mk(2, 1, 0, 0, 0, 0));
        tbl.push_back(mk(2, 1, 1, 0, 0, 0));
        tbl.push_back(mk(2, 1, 0, 0, 1, 6'b1010));
        tbl.push_back(mk(2, 1, 1, 0, 0, 0));
        tbl.push_back(mk(2, 1, 0, 1, 1, 6'b1000));
        tbl.push_back(mk(2, 0, 0, 0, 0, 0));
        tbl.push_back(mk(2, 1, 0, 0, 0, 0));
        tbl.push_back(mk(2, 1, 1, 0, 0, 0));
        tbl.push_back(mk(2, 1, 1, 0, 0, 0));
        tbl.push_back(mk(2, 1, 1, 1, 1, 6'b0111));
        tbl.push_back(mk(2, 0, 0, 0, 0, 0));
        // BPSK scrambled: first keystream bit is 0
        tbl.push_back(mk(3, 1, 1, 0, 1, 6'b1));

        foreach (tbl[i]) begin
            valIn[tbl[i].inst] = tbl[i].v;
            flush[tbl[i].inst] = tbl[i].f;
            dIn = tbl[i].d;
            cyc();
            valIn = '0;
            flush = '0;
            check($sformatf("vec%0d_val", i), valOut[tbl[i].inst], tbl[i].expV);
            if (tbl[i].expV) check($sformatf("vec%0d_dout", i), dOutA[tbl[i].inst], tbl[i].expD);
        end

        // Backpressure on QPSK: held symbol, stalled input, single transfer
        rdyOut[0] = 1'b0;
        valIn[0] = 1'b1;
        dIn = 1'b1;
        cyc();
        cyc();
        check("bp_load_val", valOut[0], 1);
        check("bp_load_dout", d0, 2'b11);
        dIn = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            check($sformatf("bp_rdyIn%0d", i), rdyIn[0], 0);
            cyc();
            check($sformatf("bp_hold_val%0d", i), valOut[0], 1);
            check($sformatf("bp_hold_dout%0d", i), d0, 2'b11);
        end
        rdyOut[0] = 1'b1;
        valIn[0] = 1'b0;
        n = 0;
        for (int i = 0; i < 4; i++) begin
            #1;
            if (valOut[0] && rdyOut[0]) n++;
            cyc();
        end
        check("bp_one_transfer", n, 1);
        check("bp_rdy_after", rdyIn[0], 1);

        runRandom(0, 2, 1'b0);
        runRandom(1, 2, 1'b1);
        runRandom(2, 4, 1'b0);
        runRandom(3, 1, 1'b1);

        // Reset after one of two QPSK scrambled bits
        doReset(1);
        valIn[1] = 1'b1;
        dIn = 1'b1;
        cyc();
        valIn[1] = 1'b0;
        check("rstmid_val0", valOut[1], 0);
        rst[1] = 1'b1;
        #1;
        check("rstmid_rdy", rdyIn[1], 0);
        cyc();
        check("rstmid_val1", valOut[1], 0);
        cyc();
        rst[1] = 1'b0;
        cyc();
        check("rstmid_val2", valOut[1], 0);
        valIn[1] = 1'b1;
        dIn = 1'b1;
        cyc();
        check("rstmid_val3", valOut[1], 0);
        dIn = 1'b0;
        cyc();
        valIn[1] = 1'b0;
        check("rstmid_val4", valOut[1], 1);
        check("rstmid_dout", d1, {1'b1 ^ ks(0), 1'b0 ^ ks(1)});

        // BPSK scrambled: flush reseeds, so a resent block repeats its output
        doReset(3);
        foreach (b3[i]) b3[i] = 1'($urandom_range(0, 1));
        for (int len = 3; len <= 8; len += 5) begin
            for (int pass = 0; pass < 2; pass++) begin
                for (int i = 0; i < len; i++) begin
                    valIn[3] = 1'b1;
                    dIn = b3[i];
                    cyc();
                    check($sformatf("reseed_l%0d_p%0d_val%0d", len, pass, i), valOut[3], 1);
                    check($sformatf("reseed_l%0d_p%0d_d%0d", len, pass, i), d3, b3[i] ^ ks(i));
                end
                valIn[3] = 1'b0;
                flush[3] = 1'b1;
                cyc();
                flush[3] = 1'b0;
                check($sformatf("reseed_l%0d_p%0d_noflushsym", len, pass), valOut[3], 0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
